operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL provide parameter NREGS, default 16, meaning number of 32-bit architectural registers; register index width is 4.
REQ-002 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide ports in_valid input 1 and in_ready output 1: decoded-instruction handshake from decode.
REQ-005 SHALL provide ports in_rs1 input 4, in_rs2 input 4, in_rd input 4: source and destination register indices.
REQ-006 SHALL provide ports in_imm input 32, in_use_imm input 1 (B operand taken from in_imm), in_aluop input 4.
REQ-007 SHALL provide ports out_valid output 1 and out_ready input 1: operand handshake to the ALU stage.
REQ-008 SHALL provide ports out_a output 32, out_b output 32, out_aluop output 4, out_rd output 4: ALU operands, op code and destination.
REQ-009 SHALL provide ports wb_en input 1, wb_rd input 4, wb_data input 32: register write-back from downstream.

Function
REQ-010 SHALL hold a 16x32 register file; r0 reads as 0; writes to r0 are ignored.
REQ-011 SHALL write wb_data into register wb_rd at the clock edge when wb_en=1 and wb_rd!=0.
REQ-012 SHALL keep a busy bit per register; r0 is never busy.
REQ-013 SHALL set busy[in_rd] on accept when in_rd!=0, and clear busy[wb_rd] on write-back; if both target one register in the same cycle, set wins.
REQ-014 SHALL treat a hazard as present when rs1 is busy, or when in_use_imm=0 and rs2 is busy, after bypass exemption (REQ-025).
REQ-015 SHALL drive in_ready = !rst && (!out_valid || out_ready) && !hazard, combinationally.
REQ-016 SHALL accept an instruction when in_valid && in_ready, and capture out_a, out_b, out_aluop, out_rd on that edge.
REQ-017 SHALL set out_valid=1 one cycle after accept; latency from accept to out_valid is exactly 1 cycle.
REQ-018 SHALL hold out_a, out_b, out_aluop, out_rd and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL clear out_valid on out_ready=1 unless a new accept occurs in the same cycle; back-to-back accepts sustain 1 instruction/cycle.
REQ-020 SHALL capture out_b = in_imm when in_use_imm=1; otherwise out_b is register rs2.
REQ-021 SHALL not update captured operands from later write-backs.
REQ-022 SHALL ignore in_valid=0 cycles; no state except write-back and busy-clear changes.

Reset
REQ-023 SHALL, on a clock edge with rst=1, clear all registers, all busy bits, out_valid, out_a, out_b, out_aluop and out_rd to 0.
REQ-024 SHALL, when reset is asserted mid-operation, discard the held output and pending busy bits, ignore wb_en in that cycle, and hold in_ready=0 while rst=1.

Configuration
REQ-025 SHALL, with macro ICE_RISC_OF_BYPASS_EN defined, forward wb_data into a captured operand when wb_en=1, wb_rd!=0 and wb_rd matches that source in the accept cycle, and exempt that source from the hazard.
REQ-026 SHALL, without ICE_RISC_OF_BYPASS_EN, capture the pre-write register value (read-before-write), apply no exemption, and stall until the busy bit has cleared; the first accept is then one cycle after the write-back.

Verification
REQ-027 Reset, then write-back r1=1234 and r2=5678; issue rs1=1, rs2=2, aluop=0 with out_ready=1 -> next cycle out_valid=1, out_a=1234, out_b=5678.
REQ-028 Issue rs1=0, use_imm=1, imm=32'h82345671 -> out_a=0, out_b=32'h82345671; a write-back to r0 keeps r0 reading 0.
REQ-029 Issue rd=3, then rs1=3 -> in_ready=0 until write-back r3=3. With bypass: accept in the write-back cycle, out_a=3. Without bypass: accept on the following cycle, out_a=3.
REQ-030 Hold out_ready=0 for 5 cycles with in_valid=1 -> outputs stay stable, in_ready=0; then out_ready=1 -> next operand set appears the following cycle with no loss or duplication.
REQ-031 Assert rst for 1 cycle while out_valid=1 and r5 is busy -> out_valid=0, all outputs 0; then rs1=5 is accepted immediately and out_a=0.
REQ-032 In one cycle, write back rd=4 while accepting an instruction with rd=4 -> busy[4] remains 1 and the next instruction reading r4 stalls.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file, per-register busy scoreboard and a one-entry operand register toward the ALU.
// Optional write-back forwarding into captured operands is enabled by defining ICE_RISC_OF_BYPASS_EN.
module operand_fetch #(
    parameter int NREGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rs1,
    input  logic [3:0]  in_rs2,
    input  logic [3:0]  in_rd,
    input  logic [31:0] in_imm,
    input  logic        in_use_imm,
    input  logic [3:0]  in_aluop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [3:0]  out_aluop,
    output logic [3:0]  out_rd,
    input  logic        wb_en,
    input  logic [3:0]  wb_rd,
    input  logic [31:0] wb_data
);
    logic [31:0]      regFile [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busyNext;
    logic             wbWrite;
    logic             accept;
    logic             hazard;
    logic             rs1Busy;
    logic             rs2Busy;
    logic [31:0]      rs1Val;
    logic [31:0]      rs2Val;
    logic [31:0]      opA;
    logic [31:0]      opB;

    assign wbWrite = wb_en && (wb_rd != 4'd0);
    assign rs1Val  = (in_rs1 == 4'd0) ? 32'd0 : regFile[in_rs1];
    assign rs2Val  = (in_rs2 == 4'd0) ? 32'd0 : regFile[in_rs2];

`ifdef ICE_RISC_OF_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // A source being written back this cycle takes the new value and is no longer a hazard.
    assign fwd1    = wbWrite && (wb_rd == in_rs1);
    assign fwd2    = wbWrite && (wb_rd == in_rs2);
    assign rs1Busy = busy[in_rs1] && !fwd1;
    assign rs2Busy = busy[in_rs2] && !fwd2;
    assign opA     = fwd1 ? wb_data : rs1Val;
    assign opB     = in_use_imm ? in_imm : (fwd2 ? wb_data : rs2Val);
`else
    assign rs1Busy = busy[in_rs1];
    assign rs2Busy = busy[in_rs2];
    assign opA     = rs1Val;
    assign opB     = in_use_imm ? in_imm : rs2Val;
`endif

    assign hazard   = rs1Busy || (!in_use_imm && rs2Busy);
    assign in_ready = !rst && (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Set after clear so a new destination claim beats a same-cycle write-back.
    always_comb begin
        busyNext = busy;
        if (wbWrite) begin
            busyNext[wb_rd] = 1'b0;
        end
        if (accept && (in_rd != 4'd0)) begin
            busyNext[in_rd] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile[i] <= 32'd0;
            end
            busy      <= '0;
            out_valid <= 1'b0;
            out_a     <= 32'd0;
            out_b     <= 32'd0;
            out_aluop <= 4'd0;
            out_rd    <= 4'd0;
        end else begin
            if (wbWrite) begin
                regFile[wb_rd] <= wb_data;
            end
            busy <= busyNext;
            if (accept) begin
                out_valid <= 1'b1;
                out_a     <= opA;
                out_b     <= opB;
                out_aluop <= in_aluop;
                out_rd    <= in_rd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios followed by random traffic against an array-based reference model.
module tb_operand_fetch;
`ifdef ICE_RISC_OF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [3:0]  inRs1;
    logic [3:0]  inRs2;
    logic [3:0]  inRd;
    logic [31:0] inImm;
    logic        inUseImm;
    logic [3:0]  inAluop;
    logic        outValid;
    logic        outReady;
    logic [31:0] outA;
    logic [31:0] outB;
    logic [3:0]  outAluop;
    logic [3:0]  outRd;
    logic        wbEn;
    logic [3:0]  wbRd;
    logic [31:0] wbData;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [3:0]  rd;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] mReg[16];
    bit          mBusy[16];
    bit          mOutValid = 1'b0;
    bit          justReset = 1'b0;
    int          nVec = 0;
    int          nErr = 0;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady),
        .in_rs1(inRs1), .in_rs2(inRs2), .in_rd(inRd),
        .in_imm(inImm), .in_use_imm(inUseImm), .in_aluop(inAluop),
        .out_valid(outValid), .out_ready(outReady),
        .out_a(outA), .out_b(outB), .out_aluop(outAluop), .out_rd(outRd),
        .wb_en(wbEn), .wb_rd(wbRd), .wb_data(wbData)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic bit forwarded(input logic [3:0] r);
        return BYPASS && wbEn && (r != 4'd0) && (wbRd == r);
    endfunction

    function automatic bit effBusy(input logic [3:0] r);
        if (r == 4'd0 || forwarded(r)) return 1'b0;
        return mBusy[r];
    endfunction

    function automatic logic [31:0] readOp(input logic [3:0] r);
        if (forwarded(r)) return wbData;
        return (r == 4'd0) ? 32'd0 : mReg[r];
    endfunction

    // Reference model: evaluates the upcoming edge from the inputs and its own architectural state.
    initial begin : model
        bit   hz;
        bit   expReady;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            mReg[i]  = 32'd0;
            mBusy[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            #1;
            if (justReset) begin
                check("reset out_a", outA, 32'd0);
                check("reset out_b", outB, 32'd0);
                check("reset out_aluop", {28'd0, outAluop}, 32'd0);
                check("reset out_rd", {28'd0, outRd}, 32'd0);
                justReset = 1'b0;
            end
            hz       = effBusy(inRs1) || (!inUseImm && effBusy(inRs2));
            expReady = !rst && (!mOutValid || outReady) && !hz;
            check("in_ready", {31'd0, inReady}, {31'd0, expReady});
            check("out_valid", {31'd0, outValid}, {31'd0, mOutValid});
            if (rst) begin
                for (int i = 0; i < 16; i++) begin
                    mReg[i]  = 32'd0;
                    mBusy[i] = 1'b0;
                end
                mOutValid = 1'b0;
                expQ.delete();
                justReset = 1'b1;
            end else begin
                if (inValid && expReady) begin
                    e.a  = readOp(inRs1);
                    e.b  = inUseImm ? inImm : readOp(inRs2);
                    e.op = inAluop;
                    e.rd = inRd;
                    expQ.push_back(e);
                end
                if (wbEn && wbRd != 4'd0) begin
                    mReg[wbRd]  = wbData;
                    mBusy[wbRd] = 1'b0;
                end
                if (inValid && expReady && inRd != 4'd0) mBusy[inRd] = 1'b1;
                if (inValid && expReady) mOutValid = 1'b1;
                else if (outReady) mOutValid = 1'b0;
            end
        end
    end

    // Monitor: every operand transfer to the ALU must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (outValid === 1'b1 && outReady && !rst) begin
                if (expQ.size() == 0) begin
                    nVec++;
                    nErr++;
                    $display("FAIL unexpected transfer: got a=%h b=%h, want no output", outA, outB);
                end else begin
                    e = expQ.pop_front();
                    check("out_a", outA, e.a);
                    check("out_b", outB, e.b);
                    check("out_aluop", {28'd0, outAluop}, {28'd0, e.op});
                    check("out_rd", {28'd0, outRd}, {28'd0, e.rd});
                end
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic [31:0] imm, input logic ui, input logic [3:0] op,
                         input logic ordy, input logic we, input logic [3:0] wr, input logic [31:0] wd);
        rst      = r;
        inValid  = v;
        inRs1    = rs1;
        inRs2    = rs2;
        inRd     = rd;
        inImm    = imm;
        inUseImm = ui;
        inAluop  = op;
        outReady = ordy;
        wbEn     = we;
        wbRd     = wr;
        wbData   = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'd1234);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 32'd5678);
        drive(0, 1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 32'h82345671, 1, 1, 1, 1, 0, 32'hdeadbeef);
        drive(0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        // rd=3 then a reader of r3 that waits for its write-back
        drive(0, 1, 0, 0, 3, 5, 1, 3, 1, 0, 0, 0);
        drive(0, 1, 3, 0, 0, 0, 1, 4, 1, 0, 0, 0);
        drive(0, 1, 3, 0, 0, 0, 1, 4, 1, 1, 3, 32'd3);
        drive(0, 1, 3, 0, 0, 0, 1, 4, 1, 0, 0, 0);
        // Downstream back-pressure
        drive(0, 1, 1, 2, 6, 0, 0, 5, 0, 0, 0, 0);
        repeat (5) drive(0, 1, 1, 2, 7, 0, 0, 6, 0, 0, 0, 0);
        repeat (3) drive(0, 1, 2, 1, 0, 0, 0, 7, 1, 0, 0, 0);
        // Reset while holding output with r5 busy
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 5, 9, 1, 8, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'd77);
        drive(0, 1, 5, 0, 0, 0, 1, 9, 1, 0, 0, 0);
        // Same-cycle claim and write-back of r4
        drive(0, 1, 0, 0, 4, 1, 1, 10, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 4, 2, 1, 11, 1, 1, 4, 32'd44);
        drive(0, 1, 4, 0, 0, 0, 1, 12, 1, 0, 0, 0);
        drive(0, 1, 4, 0, 0, 0, 1, 12, 1, 1, 4, 32'd55);
        drive(0, 1, 4, 0, 0, 0, 1, 12, 1, 0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(99, 0) < 2),
                  ($urandom_range(99, 0) < 70),
                  4'($urandom_range(7, 0)), 4'($urandom_range(7, 0)), 4'($urandom_range(7, 0)),
                  $urandom(), ($urandom_range(99, 0) < 30), 4'($urandom_range(15, 0)),
                  ($urandom_range(99, 0) < 70),
                  ($urandom_range(99, 0) < 50), 4'($urandom_range(7, 0)), $urandom());
        end

        repeat (6) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        #2;
        check("drained queue", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
